// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Column drive while idle / in reset: column 0 pulled low.
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Hex code per key, indexed [row][col].
  localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[row][col];
  endfunction

  // Active-low column drive for a column index: the reset pattern rotated left.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [7:0] twice;
    twice = {COL_RESET, COL_RESET} << idx;
    return twice[7:4];
  endfunction

  // Lowest-index row that is pulled low; callers only use it when some row is low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
    if (!r[0]) return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - two-flop synchronizer for idle-high inputs
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two flops; reset to all-ones so released keypad lines look idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner with debounce (debounce stages enabled by KEYPAD_DEBOUNCE_EN)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 6000,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]        rows_s;
  state_t            state_q, state_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              row_high;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  assign row_high  = rows_s[row_q];
  assign cols      = col_drive(col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state logic: scan columns, qualify presses, hold, qualify releases.
  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    db_cnt_d    = db_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (rows_s != 4'hF) begin
            // Column index stays put, which freezes the drive on this column.
            row_d = lowest_low_row(rows_s);
`ifdef KEYPAD_DEBOUNCE_EN
            state_d  = DEBOUNCE;
            db_cnt_d = '0;
`else
            key_code_d  = key_lookup(lowest_low_row(rows_s), col_q);
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            state_d     = HELD;
`endif
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end

      DEBOUNCE: begin
        if (row_high) begin
          state_d    = SCAN;
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          key_code_d  = key_lookup(row_q, col_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      HELD: begin
        if (row_high) begin
`ifdef KEYPAD_DEBOUNCE_EN
          state_d  = RELEASE;
          db_cnt_d = '0;
`else
          key_held_d = 1'b0;
          state_d    = SCAN;
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
`endif
        end
      end

      RELEASE: begin
        if (!row_high) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          key_held_d = 1'b0;
          state_d    = SCAN;
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      default: state_d = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized scoreboard bench for keypad_scanner
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB_CYC   = 8;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  localparam int SYNC_LAT = 2;
  localparam int BUDGET   = 4 * SCAN_DIV + DB_CYC + 40;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  logic [3:0]  exp_q[$];
  logic [3:0]  last_code;
  int          checks;
  int          errors;
  int          valid_seen;
  logic        prev_valid;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DB_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  function automatic logic [3:0] code_of(input int r, input int c);
    string keys;
    byte   ch;
    keys = "123A456B789CE0FD";
    ch = keys.getc(r * 4 + c);
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    return 4'(ch - "A" + 10);
  endfunction

  function automatic logic [3:0] drive_of(input int c);
    return 4'hF & ~(4'h1 << c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every key_valid pulse must match the oldest expected key.
  always @(negedge clk) begin
    if (reset && key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key_valid: got code %0h, required no pulse", key_code);
      end else begin
        check("key_code", key_code, exp_q.pop_front());
        check("key_held_at_valid", key_held, 1);
        valid_seen++;
      end
      if (prev_valid) begin
        checks++;
        errors++;
        $display("FAIL key_valid_width: got 2+ cycles, required 1");
      end
    end
    prev_valid = reset && key_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for cols to newly become v.
  task automatic wait_cols(input logic [3:0] v);
    int n;
    n = 0;
    while (cols == v && n < BUDGET) begin @(negedge clk); n++; end
    while (cols != v && n < BUDGET) begin @(negedge clk); n++; end
    if (cols != v) check("wait_cols_timeout", cols, v);
  endtask

  task automatic wait_accept(input int seen0);
    int n;
    n = 0;
    while (valid_seen == seen0 && n < BUDGET) begin @(negedge clk); n++; end
    check("accept_in_time", (valid_seen != seen0), 1);
  endtask

  task automatic press_release(input int r, input int c, input int nb);
    int k, seen0, n;
    k = r * 4 + c;
    exp_q.push_back(code_of(r, c));
    seen0 = valid_seen;
    pressed[k] = 1'b1;
    wait_accept(seen0);
    last_code = code_of(r, c);
    tick($urandom_range(1, 6));
    check("cols_frozen", cols, drive_of(c));
    check("held_after_accept", key_held, 1);
    if (DB_EN) begin
      for (int b = 0; b < nb; b++) begin
        pressed[k] = 1'b0;
        tick($urandom_range(1, 4));
        pressed[k] = 1'b1;
        tick($urandom_range(1, 4));
      end
      check("held_through_bounce", key_held, 1);
    end
    pressed[k] = 1'b0;
    n = 0;
    while (key_held && n < BUDGET) begin @(negedge clk); n++; end
    check("release_latency", n, SYNC_LAT + 1 + (DB_EN ? DB_CYC : 0));
    check("code_kept_on_release", key_code, last_code);
    tick($urandom_range(0, 8));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    valid_seen = 0;
    prev_valid = 1'b0;
    pressed = '0;
    last_code = 4'h0;
    reset = 1'b0;
    tick(3);
    check("rst_cols", cols, 4'b1110);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_held", key_held, 0);

    // Idle scan: each column driven for SCAN_DIV cycles in rotation.
    reset = 1'b1;
    for (int n = 0; n < 4 * SCAN_DIV * 2; n++) begin
      if (n != 0) @(negedge clk);
      check("idle_cols", cols, drive_of((n / SCAN_DIV) % 4));
    end

    // Key 6 with the bounce pattern high 3 / low 2 before final release.
    begin
      int seen0, n;
      wait_cols(drive_of(2));
      exp_q.push_back(code_of(1, 2));
      seen0 = valid_seen;
      pressed[6] = 1'b1;
      wait_accept(seen0);
      last_code = code_of(1, 2);
      tick(4);
      check("key6_cols", cols, 4'b1011);
      check("key6_held", key_held, 1);
      if (DB_EN) begin
        pressed[6] = 1'b0; tick(3);
        pressed[6] = 1'b1; tick(2);
      end
      pressed[6] = 1'b0;
      n = 0;
      while (key_held && n < BUDGET) begin @(negedge clk); n++; end
      check("key6_release_latency", n, SYNC_LAT + 1 + (DB_EN ? DB_CYC : 0));
      check("key6_code_kept", key_code, 4'h6);
    end

    // Short tap on row0 during col0 must not be accepted.
    if (DB_EN) begin
      wait_cols(drive_of(0));
      pressed[0] = 1'b1;
      tick(3);
      pressed[0] = 1'b0;
      tick(30);
      check("tap_code_unchanged", key_code, last_code);
      check("tap_not_held", key_held, 0);
    end

    // Rows 2 and 3 on col1, reset mid-qualification, then re-detection.
    begin
      int seen0, n;
      wait_cols(drive_of(1));
      pressed[2*4+1] = 1'b1;
      pressed[3*4+1] = 1'b1;
      tick(DB_EN ? 6 : 2);
      reset = 1'b0;
      tick(3);
      check("midrst_cols", cols, 4'b1110);
      check("midrst_key_code", key_code, 0);
      check("midrst_key_valid", key_valid, 0);
      check("midrst_key_held", key_held, 0);
      last_code = 4'h0;
      exp_q.push_back(code_of(2, 1));
      seen0 = valid_seen;
      reset = 1'b1;
      wait_accept(seen0);
      last_code = code_of(2, 1);
      pressed = '0;
      n = 0;
      while (key_held && n < BUDGET) begin @(negedge clk); n++; end
      check("multi_released", key_held, 0);
      check("multi_code_kept", key_code, 4'h8);
      tick(5);
    end

    // Random single-key presses with random release bounce.
    for (int i = 0; i < 14; i++) begin
      press_release($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    tick(20);
    check("pending_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
